// File: rtl/rat_intr_ctrl.sv
// -----------------------------------------------------------------------------
// rat_intr_ctrl
//
// Interrupt controller for the RAT CPU. It sits between the external INT pin
// and the control unit's FETCH/EXEC sequencer:
//   - synchronizes the asynchronous INT line and detects its rising edge
//     (or uses its level when EDGE_MODE = 0),
//   - holds a one-deep pending request,
//   - owns the interrupt-enable flag I_FLAG (SEI/CLI/acknowledge/RETI),
//   - handshakes one request at a time with the control unit (INT_REQ/INT_ACK),
//   - captures shadow copies of the C and Z flags at acknowledge,
//   - counts INT edges lost while a request was already pending.
//
// Parameters
//   SYNC_STAGES  flip-flop stages in the INT synchronizer (>= 2)
//   VECTOR       interrupt vector address driven on VEC
//   EDGE_MODE    1 = rising-edge triggered, 0 = level triggered
//
// Ports
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-high reset
//   INT         in   external interrupt line, asynchronous to CLK
//   I_SET       in   one-cycle pulse on SEI
//   I_CLR       in   one-cycle pulse on CLI
//   INT_ACK     in   control unit has entered its interrupt cycle
//   RETI        in   one-cycle pulse on RETID/RETIE
//   RETI_EN     in   1 = RETIE, 0 = RETID
//   C_FLAG      in   live carry flag
//   Z_FLAG      in   live zero flag
//   INT_REQ     out  request to the control unit (state REQ)
//   I_FLAG      out  interrupt-enable flag
//   VEC         out  interrupt vector (constant VECTOR)
//   SHAD_C      out  carry captured at acknowledge
//   SHAD_Z      out  zero captured at acknowledge
//   IN_SERVICE  out  high while the service routine runs (state SERVICE)
//   MISSED      out  saturating count of INT edges dropped while pending
// -----------------------------------------------------------------------------
module rat_intr_ctrl #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [9:0] VECTOR      = 10'h3FF,
   parameter bit         EDGE_MODE   = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       INT,
   input  logic       I_SET,
   input  logic       I_CLR,
   input  logic       INT_ACK,
   input  logic       RETI,
   input  logic       RETI_EN,
   input  logic       C_FLAG,
   input  logic       Z_FLAG,
   output logic       INT_REQ,
   output logic       I_FLAG,
   output logic [9:0] VEC,
   output logic       SHAD_C,
   output logic       SHAD_Z,
   output logic       IN_SERVICE,
   output logic [7:0] MISSED
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic                   sync_last_d_reg;

   state_t     state_reg;
   state_t     state_next;
   logic       pending_reg;
   logic       pending_next;
   logic       i_flag_reg;
   logic       i_flag_next;
   logic       shad_c_reg;
   logic       shad_z_reg;
   logic [7:0] missed_reg;
   logic [7:0] missed_next;
   logic       int_req_reg;
   logic       in_service_reg;

   // ---------------------------------------------------------------------
   // Synchronizer shift: stage 0 samples the pin, each later stage samples
   // its predecessor. The shift vector is built here and registered below.
   // ---------------------------------------------------------------------
   assign sync_next[0] = INT;

   generate
      for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         assign sync_next[gi] = sync_reg[gi-1];
      end
   endgenerate

   logic sync_last;
   logic int_rise;
   logic int_event;
   logic ack;

   assign sync_last = sync_reg[SYNC_STAGES-1];
   assign int_rise  = sync_last & ~sync_last_d_reg;
   assign int_event = EDGE_MODE ? int_rise : sync_last;

   // The only cycle in which the control unit's acknowledge is honoured.
   assign ack = (state_reg == ST_REQ) && INT_ACK;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      // Pending: acknowledge consumes the request, but a new event on the
      // same edge re-arms it so that request is not lost.
      pending_next = pending_reg;
      if (ack) begin
         pending_next = 1'b0;
      end
      if (int_event) begin
         pending_next = 1'b1;
      end
      // Level mode: while idle the request simply mirrors the pin, so a
      // line that drops before being serviced withdraws its request.
      if (!EDGE_MODE && (state_reg == ST_IDLE)) begin
         pending_next = sync_last;
      end

      // An edge arriving while a request is already held is dropped and
      // counted. On the acknowledge edge the new edge becomes the next
      // request instead, so it is not counted as lost.
      missed_next = missed_reg;
      if (int_rise && pending_reg && !ack && (missed_reg != 8'hFF)) begin
         missed_next = missed_reg + 8'd1;
      end

      // Interrupt-enable flag, highest priority first.
      if (I_CLR) begin
         i_flag_next = 1'b0;
      end else if (ack) begin
         i_flag_next = 1'b0;
      end else if (RETI && (state_reg == ST_SERVICE)) begin
         i_flag_next = RETI_EN;
      end else if (I_SET) begin
         i_flag_next = 1'b1;
      end else begin
         i_flag_next = i_flag_reg;
      end

      // Request/service sequencer. Decisions use the registered I_FLAG, so
      // SEI/CLI take effect on the edge after the flag changes.
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pending_reg && i_flag_reg) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (INT_ACK) begin
               state_next = ST_SERVICE;
            end else if (!i_flag_reg) begin
               // Masked before the CPU took it; the request stays pending.
               state_next = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (RETI) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Sequential state, including registered Moore outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync_reg        <= '0;
         sync_last_d_reg <= 1'b0;
         state_reg       <= ST_IDLE;
         pending_reg     <= 1'b0;
         i_flag_reg      <= 1'b0;
         shad_c_reg      <= 1'b0;
         shad_z_reg      <= 1'b0;
         missed_reg      <= 8'd0;
         int_req_reg     <= 1'b0;
         in_service_reg  <= 1'b0;
      end else begin
         sync_reg        <= sync_next;
         sync_last_d_reg <= sync_last;
         state_reg       <= state_next;
         pending_reg     <= pending_next;
         i_flag_reg      <= i_flag_next;
         missed_reg      <= missed_next;
         int_req_reg     <= (state_next == ST_REQ);
         in_service_reg  <= (state_next == ST_SERVICE);
         if (ack) begin
            shad_c_reg <= C_FLAG;
            shad_z_reg <= Z_FLAG;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign INT_REQ    = int_req_reg;
   assign IN_SERVICE = in_service_reg;
   assign I_FLAG     = i_flag_reg;
   assign SHAD_C     = shad_c_reg;
   assign SHAD_Z     = shad_z_reg;
   assign MISSED     = missed_reg;
   assign VEC        = VECTOR;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rat_intr_ctrl
//
// Self-checking bench for rat_intr_ctrl with default parameters. A table of
// one-cycle vectors walks through request, both return paths, masking before
// acknowledge, flag priority, lost-edge counting and retrigger. Hand-written
// sequences then cover asynchronous reset mid-service and MISSED saturation.
// -----------------------------------------------------------------------------
module tb_rat_intr_ctrl;

   logic       CLK;
   logic       RESET;
   logic       INT;
   logic       I_SET;
   logic       I_CLR;
   logic       INT_ACK;
   logic       RETI;
   logic       RETI_EN;
   logic       C_FLAG;
   logic       Z_FLAG;
   logic       INT_REQ;
   logic       I_FLAG;
   logic [9:0] VEC;
   logic       SHAD_C;
   logic       SHAD_Z;
   logic       IN_SERVICE;
   logic [7:0] MISSED;

   int total;
   int bad;

   rat_intr_ctrl dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .INT        (INT),
      .I_SET      (I_SET),
      .I_CLR      (I_CLR),
      .INT_ACK    (INT_ACK),
      .RETI       (RETI),
      .RETI_EN    (RETI_EN),
      .C_FLAG     (C_FLAG),
      .Z_FLAG     (Z_FLAG),
      .INT_REQ    (INT_REQ),
      .I_FLAG     (I_FLAG),
      .VEC        (VEC),
      .SHAD_C     (SHAD_C),
      .SHAD_Z     (SHAD_Z),
      .IN_SERVICE (IN_SERVICE),
      .MISSED     (MISSED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       int_i;
      logic       iset;
      logic       iclr;
      logic       ack;
      logic       reti;
      logic       reti_en;
      logic       c;
      logic       z;
      logic       e_req;
      logic       e_if;
      logic       e_sc;
      logic       e_sz;
      logic       e_sv;
      logic [7:0] e_m;
      logic       chk_m;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic int_i, iset, iclr, ack, reti,
                               reti_en, c, z, e_req, e_if, e_sc, e_sz,
                               e_sv, input logic [7:0] e_m,
                               input logic chk_m);
      vec_t v;
      v.int_i = int_i;  v.iset = iset;    v.iclr = iclr;  v.ack = ack;
      v.reti = reti;    v.reti_en = reti_en; v.c = c;     v.z = z;
      v.e_req = e_req;  v.e_if = e_if;    v.e_sc = e_sc;  v.e_sz = e_sz;
      v.e_sv = e_sv;    v.e_m = e_m;      v.chk_m = chk_m;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      INT = 1'b0; I_SET = 1'b0; I_CLR = 1'b0; INT_ACK = 1'b0;
      RETI = 1'b0; RETI_EN = 1'b0; C_FLAG = 1'b0; Z_FLAG = 1'b0;
   endtask

   // One INT pulse: high two cycles, low two cycles (one synchronized edge).
   task automatic int_pulse();
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         INT = (k < 2);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle_inputs();
      RESET = 1'b1;

      // Columns: INT SET CLR ACK RETI REN C Z | REQ IF SC SZ SV MISSED chk
      // Basic request, then RETIE (v0-v8; v8 is a stray ACK in IDLE).
      vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,1,0,0,0, 8'd0,1)); // v0 SEI
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0,0, 8'd0,1)); // v1 edge k
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0,0, 8'd0,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0,0, 8'd0,1)); // pending set
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,0,0, 8'd0,1)); // k+3 REQ
      vecs.push_back(mk(1,0,0,1,0,0,1,0, 0,0,1,0,1, 8'd0,1)); // ack C1 Z0
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0,1, 8'd0,1));
      vecs.push_back(mk(0,0,0,0,1,1,0,0, 0,1,1,0,0, 8'd0,1)); // RETIE
      vecs.push_back(mk(0,0,0,1,0,0,0,0, 0,1,1,0,0, 8'd0,1)); // ack ignored
      // Second request, RETID, then masked pending until SEI (v9-v21).
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,1,0,0, 8'd0,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,1,0,0, 8'd0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,1,0,0, 8'd0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,0,0, 8'd0,1));
      vecs.push_back(mk(0,0,0,1,0,0,0,1, 0,0,0,1,1, 8'd0,1)); // ack C0 Z1
      vecs.push_back(mk(0,0,0,0,1,0,0,0, 0,0,0,1,0, 8'd0,1)); // RETID
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0, 8'd0,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0, 8'd0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,0, 8'd0,1)); // pending
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,0, 8'd0,1));
      vecs.push_back(mk(0,0,0,0,1,1,0,0, 0,0,0,1,0, 8'd0,1)); // RETI in IDLE
      vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,1,0,1,0, 8'd0,1)); // SEI
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,1,0, 8'd0,1)); // REQ
      // Mask before ack (v22-v25).
      vecs.push_back(mk(0,0,1,0,0,0,0,0, 1,0,0,1,0, 8'd0,1)); // CLI
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,0, 8'd0,1)); // back to IDLE
      vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,1,0,1,0, 8'd0,1)); // SEI
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,1,0, 8'd0,1)); // REQ again
      // Three lost edges while pending (v26-v37).
      for (int e = 0; e < 3; e++) begin
         vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,1,0, 8'(e),1));
         vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,1,0, 8'(e),1));
         vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,1,0, 8'(e+1),1));
         vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,1,0, 8'(e+1),1));
      end
      // SEI and CLI together: CLI wins (v38-v41).
      vecs.push_back(mk(0,1,1,0,0,0,0,0, 1,0,0,1,0, 8'd3,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,0, 8'd3,1));
      vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,1,0,1,0, 8'd3,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,1,0, 8'd3,1));
      // Edge coincident with ack, then RETIE re-requests (v42-v47).
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,1,0, 8'd3,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,1,0,1,0, 8'd3,1));
      vecs.push_back(mk(0,0,0,1,0,0,1,1, 0,0,1,1,1, 8'd3,0)); // ack + edge
      vecs.push_back(mk(0,0,0,0,1,1,0,0, 0,1,1,1,0, 8'd3,0)); // RETIE
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,1,0, 8'd3,0)); // REQ again
      vecs.push_back(mk(0,0,0,1,0,0,1,1, 0,0,1,1,1, 8'd3,0)); // SERVICE

      // Reset state.
      repeat (2) @(negedge CLK);
      check("rst_req", -1, 32'(INT_REQ), 32'd0);
      check("rst_if",  -1, 32'(I_FLAG), 32'd0);
      check("rst_sv",  -1, 32'(IN_SERVICE), 32'd0);
      check("rst_m",   -1, 32'(MISSED), 32'd0);
      check("rst_vec", -1, 32'(VEC), 32'h3FF);
      RESET = 1'b0;

      foreach (vecs[i]) begin
         @(negedge CLK);
         INT     = vecs[i].int_i;
         I_SET   = vecs[i].iset;
         I_CLR   = vecs[i].iclr;
         INT_ACK = vecs[i].ack;
         RETI    = vecs[i].reti;
         RETI_EN = vecs[i].reti_en;
         C_FLAG  = vecs[i].c;
         Z_FLAG  = vecs[i].z;
         @(posedge CLK);
         #1;
         check("int_req",    i, 32'(INT_REQ),    32'(vecs[i].e_req));
         check("i_flag",     i, 32'(I_FLAG),     32'(vecs[i].e_if));
         check("shad_c",     i, 32'(SHAD_C),     32'(vecs[i].e_sc));
         check("shad_z",     i, 32'(SHAD_Z),     32'(vecs[i].e_sz));
         check("in_service", i, 32'(IN_SERVICE), 32'(vecs[i].e_sv));
         if (vecs[i].chk_m) begin
            check("missed", i, 32'(MISSED), 32'(vecs[i].e_m));
         end
         $display("vec %0d: req=%0b if=%0b sc=%0b sz=%0b sv=%0b missed=%0d",
                  i, INT_REQ, I_FLAG, SHAD_C, SHAD_Z, IN_SERVICE, MISSED);
      end

      // Asynchronous reset while in SERVICE, between clock edges.
      @(negedge CLK);
      idle_inputs();
      #2;
      RESET = 1'b1;
      #1;
      check("arst_req", 100, 32'(INT_REQ),    32'd0);
      check("arst_sv",  100, 32'(IN_SERVICE), 32'd0);
      check("arst_if",  100, 32'(I_FLAG),     32'd0);
      check("arst_sc",  100, 32'(SHAD_C),     32'd0);
      check("arst_sz",  100, 32'(SHAD_Z),     32'd0);
      check("arst_m",   100, 32'(MISSED),     32'd0);
      check("arst_vec", 100, 32'(VEC),        32'h3FF);
      $display("async reset: req=%0b sv=%0b if=%0b missed=%0d vec=%0h",
               INT_REQ, IN_SERVICE, I_FLAG, MISSED, VEC);

      // MISSED saturation: take one request, then 300 further edges.
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      I_SET = 1'b1;
      @(negedge CLK);
      I_SET = 1'b0;
      int_pulse();
      begin
         int waited;
         waited = 0;
         while (!INT_REQ && waited < 10) begin
            @(negedge CLK);
            waited++;
         end
         check("sat_req_seen", 200, 32'(INT_REQ), 32'd1);
      end
      for (int e = 1; e <= 300; e++) begin
         int_pulse();
         if (e == 10) begin
            check("sat_m10", 201, 32'(MISSED), 32'd10);
         end
         if (e == 255) begin
            check("sat_m255", 202, 32'(MISSED), 32'd255);
         end
      end
      repeat (3) @(negedge CLK);
      check("sat_m300", 203, 32'(MISSED), 32'd255);
      check("sat_req",  203, 32'(INT_REQ), 32'd1);
      $display("saturation: missed=%0d req=%0b", MISSED, INT_REQ);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d",
               total, bad);
      $fatal(1);
   end

endmodule
